// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues word reads on a req/ready handshake and hands words to the control unit.
// Optional FETCH_MISALIGN_CHK_EN: a misaligned taken redirect raises sticky misalign_err and halts fetch.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic        pcsrc,
  input  logic [31:0] br_offset,
  output logic [7:0]  squash_cnt
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign_err
`endif
);

  // state   | meaning
  // FETCH   | request outstanding at pc (idle for one cycle after reset)
  // HOLD    | instr valid, waiting for downstream to take it
  // DRAIN   | redirect seen while request pending; finish and discard it
  // HALT    | misaligned redirect seen; fetch stopped until reset
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    S_HALT  = 2'd3
`endif
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q, addr_q, tgt_q, instr_q, instr_pc_q;
  logic        req_q, valid_q;
  logic [7:0]  squash_q;

  logic        taken, good_redir;
  logic [31:0] raw_tgt, tgt_d, drain_tgt_d;
  logic [7:0]  squash_d;

  assign taken    = redirect_valid & ~pcsrc;
  assign raw_tgt  = instr_pc_q + br_offset;
  assign squash_d = (squash_q == 8'hFF) ? squash_q : squash_q + 8'd1;

`ifdef FETCH_MISALIGN_CHK_EN
  logic err_q, halt_pend_q, bad_redir;
  assign tgt_d        = raw_tgt;
  assign bad_redir    = taken & (raw_tgt[1:0] != 2'b00);
  assign good_redir   = taken & ~bad_redir;
  assign misalign_err = err_q;
`else
  assign tgt_d      = raw_tgt & 32'hFFFF_FFFC;
  assign good_redir = taken;
`endif

  // In DRAIN the newest redirect wins, including one arriving with imem_ready.
  assign drain_tgt_d = good_redir ? tgt_d : tgt_q;

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign squash_cnt  = squash_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      tgt_q       <= RESET_PC;
      req_q       <= 1'b0;
      instr_q     <= NOP_INSTR;
      instr_pc_q  <= 32'h0;
      valid_q     <= 1'b0;
      squash_q    <= 8'h00;
`ifdef FETCH_MISALIGN_CHK_EN
      err_q       <= 1'b0;
      halt_pend_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_FETCH: begin
`ifdef FETCH_MISALIGN_CHK_EN
          if (bad_redir) begin
            err_q <= 1'b1;
            if (!req_q || imem_ready) begin
              if (req_q) squash_q <= squash_d;
              req_q   <= 1'b0;
              state_q <= S_HALT;
            end else begin
              halt_pend_q <= 1'b1;
              state_q     <= S_DRAIN;
            end
          end else
`endif
          if (!req_q) begin
            req_q <= 1'b1;
            if (good_redir) begin
              pc_q   <= tgt_d;
              addr_q <= tgt_d;
            end
          end else if (good_redir) begin
            if (imem_ready) begin
              squash_q <= squash_d;
              pc_q     <= tgt_d;
              addr_q   <= tgt_d;
            end else begin
              tgt_q   <= tgt_d;
              state_q <= S_DRAIN;
            end
          end else if (imem_ready) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
            pc_q       <= pc_q + 32'd4;
            req_q      <= 1'b0;
            state_q    <= S_HOLD;
          end
        end

        S_HOLD: begin
`ifdef FETCH_MISALIGN_CHK_EN
          if (bad_redir) begin
            err_q   <= 1'b1;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            if (!instr_ready) squash_q <= squash_d;
            state_q <= S_HALT;
          end else
`endif
          if (good_redir) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            if (!instr_ready) squash_q <= squash_d;
            pc_q    <= tgt_d;
            addr_q  <= tgt_d;
            req_q   <= 1'b1;
            state_q <= S_FETCH;
          end else if (instr_ready) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            addr_q  <= pc_q;
            req_q   <= 1'b1;
            state_q <= S_FETCH;
          end
        end

        S_DRAIN: begin
`ifdef FETCH_MISALIGN_CHK_EN
          if (bad_redir) begin
            err_q       <= 1'b1;
            halt_pend_q <= 1'b1;
          end
`endif
          if (imem_ready) begin
            squash_q <= squash_d;
`ifdef FETCH_MISALIGN_CHK_EN
            if (halt_pend_q || bad_redir) begin
              req_q   <= 1'b0;
              state_q <= S_HALT;
            end else
`endif
            begin
              pc_q    <= drain_tgt_d;
              addr_q  <= drain_tgt_d;
              state_q <= S_FETCH;
            end
          end else if (good_redir) begin
            tgt_q <= tgt_d;
          end
        end

`ifdef FETCH_MISALIGN_CHK_EN
        S_HALT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
`endif

        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage directly upstream of the control unit. Holds the PC and issues word reads to instruction memory over a req/ready handshake. Presents each fetched word as instr, with instr_pc and a valid/ready handshake, to the control unit and datapath. Consumes the control unit's pcsrc branch decision (0 = branch, 1 = next) as a redirect, then squashes wrong-path fetches.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INSTR, 32'h00000013, value driven on instr while instr_valid=0 (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, synchronous, active-low
imem_req  out  1  fetch request; held high until imem_ready
imem_addr  out  32  fetch byte address; stable while imem_req=1
imem_ready  in  1  memory accepts the request and imem_rdata is valid this cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  instruction to the control unit and datapath
instr_pc  out  32  byte address of instr
instr_valid  out  1  instr holds a live instruction
instr_ready  in  1  downstream consumes instr this cycle
redirect_valid  in  1  branch resolution strobe for the instruction at instr_pc
pcsrc  in  1  0 = take branch, 1 = next (sequential)
br_offset  in  32  signed byte offset, already sign-extended and scaled
squash_cnt  out  8  saturating count of discarded fetches

Behaviour:
- Reset (rst=0 at posedge): pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=RESET_PC, instr=NOP_INSTR, instr_pc=0, instr_valid=0, squash_cnt=0. The first cycle after rst=1 drives imem_req=1 with imem_addr=RESET_PC. Reset asserted mid-transaction abandons the outstanding request. The memory must tolerate a dropped req.
- Redirect target = instr_pc + br_offset, 32-bit wrap-around, carry discarded. It is computed only when redirect_valid=1 and pcsrc=0. redirect_valid with pcsrc=1 is a no-op.
- FETCH state: imem_req=1, imem_addr=pc.
  - imem_ready=1 and no taken redirect: next cycle instr=imem_rdata, instr_pc=pc, instr_valid=1, pc=pc+4 (wraps at 2^32), state=HOLD.
  - imem_ready=1 with a taken redirect in the same cycle: data discarded, squash_cnt+1, pc=target, stay FETCH.
  - imem_ready=0 with a taken redirect: latch target, state=DRAIN.
- HOLD state: imem_req=0, instr/instr_pc stable.
  - instr_ready=1: instr_valid=0, instr=NOP_INSTR, state=FETCH. Throughput is 1 instruction per 2 cycles minimum; fetch-to-valid latency is 1 cycle after imem_ready.
  - Taken redirect (with or without instr_ready): instr_valid=0, pc=target, state=FETCH. squash_cnt+1 only if instr_ready=0.
- DRAIN state: imem_req=1 held at the old imem_addr.
  - imem_ready=1: data discarded, squash_cnt+1, pc=latched target, state=FETCH.
  - A further taken redirect in DRAIN overwrites the latched target. The newest redirect wins. If it arrives in the same cycle as imem_ready, it is the one loaded.
- squash_cnt saturates at 8'hFF and clears only on reset.
- imem_addr[1:0] is always 2'b00 (see the optional feature for target bits [1:0]).

Optional Feature:
Macro FETCH_MISALIGN_CHK_EN.
- Defined: adds output misalign_err (1 bit, reset 0) and state HALT. A taken redirect with target[1:0]!=0 does not update pc. It sets misalign_err=1 (sticky until reset), drops instr_valid, and enters HALT. If in DRAIN, the outstanding request is completed and discarded first. HALT holds imem_req=0 and instr_valid=0 until reset.
- Not defined: no port, no HALT state; target[1:0] is forced to 2'b00 before loading pc.

Test Plan:
- Reset release, memory returns 32'h00500093 at addr 0 with imem_ready on the 2nd req cycle -> instr_valid=1 one cycle later, instr=32'h00500093, instr_pc=0, then imem_addr=4 after instr_ready.
- Sequential run with imem_ready always 1 and instr_ready always 1 -> addresses 0,4,8,C issued on alternate cycles; pc wraps 32'hFFFFFFFC -> 0 when RESET_PC=32'hFFFFFFFC.
- HOLD with instr_pc=32'h10, redirect_valid=1, pcsrc=0, br_offset=32'hFFFFFFF8, instr_ready=0 -> next imem_addr=32'h08, instr_valid=0, squash_cnt=1.
- Redirect in FETCH while imem_ready=0 for 3 cycles (target 32'h40), then a second redirect to 32'h80 before ready -> one response discarded, next imem_addr=32'h80, imem_addr unchanged during DRAIN.
- redirect_valid=1, pcsrc=1 in HOLD -> no state change, instr stable; rst=0 mid-DRAIN -> all outputs at reset values next cycle.
- Misaligned target 32'h22: with FETCH_MISALIGN_CHK_EN -> misalign_err=1, imem_req stays 0; without it -> imem_addr=32'h20.
